// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath:
// instruction fields and status flow in, enables and selects flow out.
interface multicycle_control_fsm_if;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       RegWrite;
  logic       instr_done;
  logic       illegal_instr;

  // Datapath side: supplies instruction fields and flags, consumes controls.
  modport master (
    output Op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, instr_done, illegal_instr
  );

  // Sequencer side.
  modport slave (
    input  Op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, instr_done, illegal_instr
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for a multicycle RV32I datapath with one shared ALU and a
// unified memory; stalls on mem_ready and forces all controls idle in reset.
module multicycle_control_fsm (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.slave  bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;

  localparam logic [3:0] RESET_STATE = FETCH;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  logic [3:0] state;
  logic [3:0] state_nxt;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [3:0] alu_ctl;
  logic [3:0] alu_dec;
  logic       reg_write;
  logic       done;
  logic       illegal;
  logic       br_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  // Only beq/bne are implemented; other branch funct3 values decode as illegal.
  assign br_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);

  always_comb begin
    imm_src = 2'b00;
    case (bus.Op)
      OP_LW, OP_ITYPE: imm_src = 2'b00;
      OP_SW:           imm_src = 2'b01;
      OP_BR:           imm_src = 2'b10;
      OP_JAL:          imm_src = 2'b11;
      default:         imm_src = 2'b00;
    endcase
  end

  // Shared R/I decode; SUB is only legal in R form since I form has no SUBI.
  always_comb begin
    alu_dec = ALU_ADD;
    case (bus.funct3)
      3'b000: alu_dec = (bus.Op == OP_RTYPE && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_dec = ALU_SLL;
      3'b010: alu_dec = ALU_SLT;
      3'b011: alu_dec = ALU_SLTU;
      3'b100: alu_dec = ALU_XOR;
      3'b101: alu_dec = bus.funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_dec = ALU_OR;
      3'b111: alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_nxt  = FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_ctl    = ALU_ADD;
    reg_write  = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURES;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
        state_nxt  = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is computed here so BRANCH can reuse the ALU for SUB.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (bus.Op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTER;
          OP_ITYPE:     state_nxt = EXECUTEI;
          OP_JAL:       state_nxt = JAL;
          OP_BR: begin
            state_nxt = br_ok ? BRANCH : FETCH;
            illegal   = !br_ok;
          end
          default: begin
            state_nxt = FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_nxt = (bus.Op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src   = 1'b1;
        state_nxt = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_nxt  = FETCH;
      end
      MEMWRITE: begin
        // Strobe stays up through the stall so the memory sees a stable request.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        done      = bus.mem_ready;
        state_nxt = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_ctl   = alu_dec;
        state_nxt = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_ctl   = alu_dec;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_nxt  = FETCH;
      end
      BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_ctl    = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write   = bus.funct3[0] ? !bus.Zero : bus.Zero;
        done       = 1'b1;
        state_nxt  = FETCH;
      end
      JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_nxt  = ALUWB;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign bus.PCWrite       = !reset && pc_write;
  assign bus.AdrSrc        = !reset && adr_src;
  assign bus.MemWrite      = !reset && mem_write;
  assign bus.IRWrite       = !reset && ir_write;
  assign bus.RegWrite      = !reset && reg_write;
  assign bus.instr_done    = !reset && done;
  assign bus.illegal_instr = !reset && illegal;
  assign bus.ResultSrc     = reset ? 2'b00 : result_src;
  assign bus.ALUSrcA       = reset ? 2'b00 : alu_src_a;
  assign bus.ALUSrcB       = reset ? 2'b00 : alu_src_b;
  assign bus.ImmSrc        = reset ? 2'b00 : imm_src;
  assign bus.ALUControl    = reset ? 4'b0000 : alu_ctl;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed per-cycle check of the multicycle sequencer: each step queues the
// expected control word and compares it against the outputs mid-cycle.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [3:0] alu;
    logic       rw;
    logic       done;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [1:0] cur_imm;
  ctl_t exp_q[$];
  string tag_q[$];

  multicycle_control_fsm_if bus();

  multicycle_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t e_idle();
    ctl_t e;
    e = '0;
    return e;
  endfunction

  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t e;
    e = '0;
    e.pcw = rdy; e.irw = rdy; e.rs = 2'b10; e.sb = 2'b10;
    return e;
  endfunction

  function automatic ctl_t e_decode(input logic ill);
    ctl_t e;
    e = '0;
    e.sa = 2'b01; e.sb = 2'b01; e.ill = ill;
    return e;
  endfunction

  function automatic ctl_t e_memadr();
    ctl_t e;
    e = '0;
    e.sa = 2'b10; e.sb = 2'b01;
    return e;
  endfunction

  function automatic ctl_t e_memread();
    ctl_t e;
    e = '0;
    e.adr = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_memwb();
    ctl_t e;
    e = '0;
    e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_memwrite(input logic rdy);
    ctl_t e;
    e = '0;
    e.adr = 1'b1; e.mw = 1'b1; e.done = rdy;
    return e;
  endfunction

  function automatic ctl_t e_exec(input logic rform, input logic [3:0] alu);
    ctl_t e;
    e = '0;
    e.sa = 2'b10; e.sb = rform ? 2'b00 : 2'b01; e.alu = alu;
    return e;
  endfunction

  function automatic ctl_t e_aluwb();
    ctl_t e;
    e = '0;
    e.rw = 1'b1; e.done = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_branch(input logic take);
    ctl_t e;
    e = '0;
    e.sa = 2'b10; e.alu = 4'b0001; e.pcw = take; e.done = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_jal();
    ctl_t e;
    e = '0;
    e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
    return e;
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [1:0] imm);
    bus.Op = op; bus.funct3 = f3; bus.funct7b5 = f7; cur_imm = imm;
  endtask

  // Drive one cycle's inputs, queue the expectation, check mid-cycle, advance.
  task automatic step(input string tag, input logic rst, input logic rdy,
                      input logic z, input ctl_t e);
    ctl_t got;
    ctl_t want;
    string t;
    reset = rst; bus.mem_ready = rdy; bus.Zero = z;
    if (!rst) e.imm = cur_imm;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    got = '{pcw: bus.PCWrite, adr: bus.AdrSrc, mw: bus.MemWrite, irw: bus.IRWrite,
            rs: bus.ResultSrc, sa: bus.ALUSrcA, sb: bus.ALUSrcB, imm: bus.ImmSrc,
            alu: bus.ALUControl, rw: bus.RegWrite, done: bus.instr_done,
            ill: bus.illegal_instr};
    want = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", t, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.Zero = 1'b0;
    set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
    @(posedge clk);
    #1;

    step("rst0", 1, 0, 0, e_idle());
    step("rst1", 1, 1, 0, e_idle());

    // add x3,x1,x2
    set_instr(7'b0110011, 3'b000, 1'b0, 2'b00);
    step("add_f",  0, 1, 0, e_fetch(1));
    step("add_d",  0, 1, 0, e_decode(0));
    step("add_x",  0, 1, 0, e_exec(1, 4'b0000));
    step("add_wb", 0, 1, 0, e_aluwb());
    // sub
    set_instr(7'b0110011, 3'b000, 1'b1, 2'b00);
    step("sub_f",  0, 1, 0, e_fetch(1));
    step("sub_d",  0, 1, 0, e_decode(0));
    step("sub_x",  0, 1, 0, e_exec(1, 4'b0001));
    step("sub_wb", 0, 1, 0, e_aluwb());
    // sltu (R)
    set_instr(7'b0110011, 3'b011, 1'b0, 2'b00);
    step("sltu_f",  0, 1, 0, e_fetch(1));
    step("sltu_d",  0, 1, 0, e_decode(0));
    step("sltu_x",  0, 1, 0, e_exec(1, 4'b0110));
    step("sltu_wb", 0, 1, 0, e_aluwb());
    // srai, and addi with funct7b5 set must stay ADD
    set_instr(7'b0010011, 3'b101, 1'b1, 2'b00);
    step("srai_f",  0, 1, 0, e_fetch(1));
    step("srai_d",  0, 1, 0, e_decode(0));
    step("srai_x",  0, 1, 0, e_exec(0, 4'b1001));
    step("srai_wb", 0, 1, 0, e_aluwb());
    set_instr(7'b0010011, 3'b000, 1'b1, 2'b00);
    step("addi_f",  0, 1, 0, e_fetch(1));
    step("addi_d",  0, 1, 0, e_decode(0));
    step("addi_x",  0, 1, 0, e_exec(0, 4'b0000));
    step("addi_wb", 0, 1, 0, e_aluwb());

    // lw with three stall cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
    step("lw_f",   0, 1, 0, e_fetch(1));
    step("lw_d",   0, 1, 0, e_decode(0));
    step("lw_ma",  0, 1, 0, e_memadr());
    for (int i = 0; i < 3; i++) step("lw_mr_stall", 0, 0, 0, e_memread());
    step("lw_mr",  0, 1, 0, e_memread());
    step("lw_wb",  0, 1, 0, e_memwb());

    // sw with a fetch stall and two write stalls
    set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
    step("sw_f_stall", 0, 0, 0, e_fetch(0));
    step("sw_f",   0, 1, 0, e_fetch(1));
    step("sw_d",   0, 1, 0, e_decode(0));
    step("sw_ma",  0, 1, 0, e_memadr());
    step("sw_mw0", 0, 0, 0, e_memwrite(0));
    step("sw_mw1", 0, 0, 0, e_memwrite(0));
    step("sw_mw2", 0, 1, 0, e_memwrite(1));

    // branches: the fetch following sw also shows MemWrite dropped
    set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
    step("beq1_f",  0, 1, 0, e_fetch(1));
    step("beq1_d",  0, 1, 0, e_decode(0));
    step("beq1_br", 0, 1, 1, e_branch(1));
    step("beq0_f",  0, 1, 0, e_fetch(1));
    step("beq0_d",  0, 1, 0, e_decode(0));
    step("beq0_br", 0, 1, 0, e_branch(0));
    set_instr(7'b1100011, 3'b001, 1'b0, 2'b10);
    step("bne0_f",  0, 1, 0, e_fetch(1));
    step("bne0_d",  0, 1, 0, e_decode(0));
    step("bne0_br", 0, 1, 0, e_branch(1));
    step("bne1_f",  0, 1, 1, e_fetch(1));
    step("bne1_d",  0, 1, 1, e_decode(0));
    step("bne1_br", 0, 1, 1, e_branch(0));
    set_instr(7'b1100011, 3'b100, 1'b0, 2'b10);
    step("blt_f",   0, 1, 0, e_fetch(1));
    step("blt_d",   0, 1, 0, e_decode(1));

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
    step("jal_f",   0, 1, 0, e_fetch(1));
    step("jal_d",   0, 1, 0, e_decode(0));
    step("jal_j",   0, 1, 0, e_jal());
    step("jal_wb",  0, 1, 0, e_aluwb());

    // illegal opcode 0x7F
    set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
    step("ill_f",   0, 1, 0, e_fetch(1));
    step("ill_d",   0, 1, 0, e_decode(1));
    step("ill_next", 0, 1, 0, e_fetch(1));
    step("ill_d2",  0, 1, 0, e_decode(1));

    // reset while stalled in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
    step("rsw_f",   0, 1, 0, e_fetch(1));
    step("rsw_d",   0, 1, 0, e_decode(0));
    step("rsw_ma",  0, 1, 0, e_memadr());
    step("rsw_mw",  0, 0, 0, e_memwrite(0));
    step("rsw_rst", 1, 0, 0, e_idle());
    step("rsw_f2",  0, 1, 0, e_fetch(1));
    step("rsw_d2",  0, 1, 0, e_decode(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for a multicycle RV32I datapath with one shared ALU and a unified instruction/data memory.
- Holds the instruction phase in a Moore FSM and issues per-state enables, mux selects and ALU operations.
- Stalls on a memory ready handshake.
- Sits beside the existing single-cycle decode path and reuses its ALUControl encoding and ImmSrc encoding.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset; fixed, not for override.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- Op  in  7  opcode, taken from the instruction register
- funct3  in  3  instruction bits [14:12]
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU zero flag, valid in the BRANCH state
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut drives the memory address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = MemData, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = Imm, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  4  ALU operation code
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
- Reset: state becomes FETCH. While reset is high, PCWrite, IRWrite, MemWrite, RegWrite, instr_done and illegal_instr are 0; all selects are 0 and ALUControl is 0000.
- Reset mid-instruction abandons the instruction. No write enable is asserted in the reset cycle.
- Outputs are combinational from state, plus Op/funct3/funct7b5/Zero where listed. ImmSrc is a pure function of Op:
  - lw and I-ALU: 00
  - sw: 01
  - beq/bne: 10
  - jal: 11
  - others: 00
- ALUControl encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
- Decoded ALU op, by funct3:
  - 000: ADD; SUB only when Op = 0110011 and funct7b5 = 1
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL if funct7b5 = 0, else SRA (both R and I forms)
  - 110: OR
  - 111: AND
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ADD, ResultSrc 10. IRWrite and PCWrite equal mem_ready. Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE: ALUSrcA 01, ALUSrcB 01, ADD (branch target into ALUOut). Next state by Op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 with funct3 ∈ {000, 001} → BRANCH
  - 1101111 → JAL
  - otherwise → FETCH, with illegal_instr = 1 for that cycle
- MEMADR: ALUSrcA 10, ALUSrcB 01, ADD. Next: lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: AdrSrc 1. Hold while !mem_ready; mem_ready → MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1, instr_done 1 → FETCH.
- MEMWRITE: AdrSrc 1, MemWrite 1, held continuously until mem_ready. On the mem_ready cycle: instr_done 1 → FETCH.
- EXECUTER: ALUSrcA 10, ALUSrcB 00, decoded op → ALUWB.
- EXECUTEI: ALUSrcA 10, ALUSrcB 01, decoded op → ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1, instr_done 1 → FETCH.
- BRANCH: ALUSrcA 10, ALUSrcB 00, SUB, ResultSrc 00.
  - PCWrite = Zero for beq (funct3 000), !Zero for bne (funct3 001).
  - instr_done 1 → FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, ADD, ResultSrc 00, PCWrite 1 → ALUWB (writes PC+4 to rd; instr_done is pulsed there, once only).
- Latency with mem_ready tied high:
  - lw: 5 cycles
  - sw: 4 cycles
  - R/I: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
- Each stall cycle on mem_ready adds one cycle.
- Unused outputs in a state are 0. PCWrite and RegWrite are never both high except in JAL→ALUWB order, i.e. never in the same cycle.
- instr_done pulses exactly once per retired instruction; it is never asserted for an illegal opcode.

Test Plan:
- Reset held 2 cycles, then released with mem_ready = 1 → first cycle in FETCH with IRWrite = 1, PCWrite = 1, ALUSrcB = 10, ALUControl = 0000; no enables asserted during reset.
- add x3,x1,x2 (0x002081B3), then sub (funct7b5 = 1), mem_ready = 1 → DECODE, EXECUTER, ALUWB. ALUControl 0000, then 0001. RegWrite only in cycle 4. instr_done once.
- lw with mem_ready low 3 cycles in MEMREAD → state holds MEMREAD with AdrSrc = 1. Then MEMWB with ResultSrc = 01 and RegWrite = 1. Total 8 cycles.
- sw with mem_ready low 2 cycles → MemWrite held high for 3 consecutive cycles, drops after the mem_ready cycle, ImmSrc = 01.
- beq with Zero = 1 → PCWrite 1 in BRANCH. beq with Zero = 0 → PCWrite 0. bne with Zero = 0 → PCWrite 1. ALUControl = 0001 and ImmSrc = 10 in all cases.
- Opcode 0x7F → illegal_instr pulses in DECODE, next state is FETCH, no RegWrite/MemWrite. A reset asserted in MEMWRITE → MemWrite 0 that cycle and state FETCH.
